// File: rtl/ctech_lib_pkg.sv
// Shared constants for the ctech library cells.
// Holds legal parameter limits and a counter-width helper.
package ctech_lib_pkg;

  localparam int unsigned CTECH_SYNC_MAX_WIDTH  = 32;
  localparam int unsigned CTECH_SYNC_MAX_STAGES = 4;
  localparam int unsigned CTECH_SYNC_MAX_FILT   = 15;

  function automatic int unsigned ctech_cnt_w(
    input int unsigned filt
  );
    return (filt > 0) ? $clog2(filt + 1) : 1;
  endfunction

endpackage

// File: rtl/ctech_lib_inv_sync_ch.sv
// One channel: synchroniser chain, polarity fix,
// persistence filter and registered edge pulses.
module ctech_lib_inv_sync_ch
  import ctech_lib_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter bit          INV     = 1'b1,
  parameter int unsigned FILT    = 0,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic a,
  output logic o1,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = ctech_cnt_w(FILT);
  localparam logic [CW-1:0] FILT_C = CW'(FILT);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic              p;
  logic              upd;

  // Reset value chosen so p matches o1 after reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= {STAGES{RST_VAL ^ INV}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], a};
    end
  end

  assign p = sync_q[STAGES-1] ^ INV;

  always_comb begin
    upd   = 1'b0;
    cnt_d = cnt;
    if (p == o1) begin
      cnt_d = '0;
    end else if (cnt == FILT_C) begin
      upd   = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt  <= '0;
      o1   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      o1   <= upd ? p : o1;
      rise <= upd & p;
      fall <= upd & ~p;
    end
  end

endmodule

// File: rtl/ctech_lib_inv_sync.sv
// Multi-channel inverting synchroniser with optional
// glitch filter and edge pulses.
module ctech_lib_inv_sync
  import ctech_lib_pkg::*;
#(
  parameter int unsigned     WIDTH    = 1,
  parameter int unsigned     STAGES   = 2,
  parameter logic [WIDTH-1:0] INV_MASK = '1,
  parameter int unsigned     FILT     = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 1 || WIDTH > CTECH_SYNC_MAX_WIDTH) begin : g_bad_width
    $error("ctech_lib_inv_sync: WIDTH out of range");
  end
  if (STAGES < 2 || STAGES > CTECH_SYNC_MAX_STAGES) begin : g_bad_stages
    $error("ctech_lib_inv_sync: STAGES out of range");
  end
  if (FILT > CTECH_SYNC_MAX_FILT) begin : g_bad_filt
    $error("ctech_lib_inv_sync: FILT out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ctech_lib_inv_sync_ch #(
      .STAGES  (STAGES),
      .INV     (INV_MASK[i]),
      .FILT    (FILT),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rstb (rstb),
      .a    (a[i]),
      .o1   (o1[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_ctech_lib_inv_sync.sv
// Randomised bench for ctech_lib_inv_sync over four
// parameter sets against a delay-line/run-length model.
module tb_ctech_lib_inv_sync;

  localparam int NI = 4;
  localparam int          WD[NI]   = '{8, 4, 4, 2};
  localparam int          ST[NI]   = '{2, 3, 4, 2};
  localparam int          FL[NI]   = '{0, 3, 1, 15};
  localparam logic [7:0]  INVM[NI] = '{8'hA5, 8'h00, 8'h0F, 8'h00};
  localparam logic [7:0]  RSTV[NI] = '{8'h00, 8'h05, 8'h00, 8'h02};

  logic clk = 1'b0;
  logic rstb;
  logic [7:0] a_v[NI];
  logic [7:0] o1_v[NI];
  logic [7:0] rise_v[NI];
  logic [7:0] fall_v[NI];

  logic [7:0] o0, r0, f0;
  logic [3:0] o1w, r1, f1;
  logic [3:0] o2, r2, f2;
  logic [1:0] o3, r3, f3;

  int n_chk = 0;
  int n_pass = 0;

  bit         dq[NI][8][$];
  int         run[NI][8];
  logic [7:0] o1m[NI];
  logic [7:0] risem[NI];
  logic [7:0] fallm[NI];

  always #5 clk = ~clk;

  ctech_lib_inv_sync #(
    .WIDTH(8), .STAGES(2), .INV_MASK(8'hA5),
    .FILT(0), .RST_VAL(8'h00)
  ) u0 (
    .clk(clk), .rstb(rstb), .a(a_v[0]),
    .o1(o0), .rise(r0), .fall(f0)
  );

  ctech_lib_inv_sync #(
    .WIDTH(4), .STAGES(3), .INV_MASK(4'h0),
    .FILT(3), .RST_VAL(4'h5)
  ) u1 (
    .clk(clk), .rstb(rstb), .a(a_v[1][3:0]),
    .o1(o1w), .rise(r1), .fall(f1)
  );

  ctech_lib_inv_sync #(
    .WIDTH(4), .STAGES(4), .INV_MASK(4'hF),
    .FILT(1), .RST_VAL(4'h0)
  ) u2 (
    .clk(clk), .rstb(rstb), .a(a_v[2][3:0]),
    .o1(o2), .rise(r2), .fall(f2)
  );

  ctech_lib_inv_sync #(
    .WIDTH(2), .STAGES(2), .INV_MASK(2'b00),
    .FILT(15), .RST_VAL(2'b10)
  ) u3 (
    .clk(clk), .rstb(rstb), .a(a_v[3][1:0]),
    .o1(o3), .rise(r3), .fall(f3)
  );

  assign o1_v[0] = o0;
  assign o1_v[1] = {4'b0, o1w};
  assign o1_v[2] = {4'b0, o2};
  assign o1_v[3] = {6'b0, o3};
  assign rise_v[0] = r0;
  assign rise_v[1] = {4'b0, r1};
  assign rise_v[2] = {4'b0, r2};
  assign rise_v[3] = {6'b0, r3};
  assign fall_v[0] = f0;
  assign fall_v[1] = {4'b0, f1};
  assign fall_v[2] = {4'b0, f2};
  assign fall_v[3] = {6'b0, f3};

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] wmask(input int k);
    return 8'((16'h1 << WD[k]) - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      o1m[k]   = RSTV[k] & wmask(k);
      risem[k] = '0;
      fallm[k] = '0;
      for (int c = 0; c < 8; c++) begin
        run[k][c] = 0;
        dq[k][c].delete();
        for (int s = 0; s < ST[k]; s++)
          dq[k][c].push_back(RSTV[k][c] ^ INVM[k][c]);
      end
    end
  endtask

  // Delay line of raw samples; o1 follows p once it has
  // differed for more than FILT consecutive edges.
  task automatic model_step();
    bit p;
    for (int k = 0; k < NI; k++) begin
      risem[k] = '0;
      fallm[k] = '0;
      for (int c = 0; c < WD[k]; c++) begin
        p = dq[k][c][$] ^ INVM[k][c];
        if (p == o1m[k][c]) begin
          run[k][c] = 0;
        end else begin
          run[k][c] = run[k][c] + 1;
          if (run[k][c] > FL[k]) begin
            o1m[k][c] = p;
            run[k][c] = 0;
            if (p) risem[k][c] = 1'b1;
            else   fallm[k][c] = 1'b1;
          end
        end
        dq[k][c].push_front(a_v[k][c]);
        void'(dq[k][c].pop_back());
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.u%0d.o1", ph, k), o1_v[k], o1m[k]);
      chk($sformatf("%s.u%0d.rise", ph, k), rise_v[k], risem[k]);
      chk($sformatf("%s.u%0d.fall", ph, k), fall_v[k], fallm[k]);
      chk($sformatf("%s.u%0d.excl", ph, k),
          rise_v[k] & fall_v[k], 8'h00);
    end
  endtask

  task automatic drive(input int cyc);
    int div;
    if (cyc < 40) begin
      for (int k = 0; k < NI; k++) a_v[k] = 8'h00;
    end else if (cyc < 80) begin
      for (int k = 0; k < NI; k++) a_v[k] = 8'hFF;
    end else if (cyc < 280) begin
      // p toggles every 8 cycles: too short for FILT=15
      if (cyc % 8 == 0)
        for (int k = 0; k < NI; k++) a_v[k] = ~a_v[k];
    end else begin
      case ((cyc / 100) % 3)
        0:       div = 2;
        1:       div = 6;
        default: div = 30;
      endcase
      for (int k = 0; k < NI; k++)
        for (int c = 0; c < 8; c++)
          if ($urandom_range(div - 1) == 0)
            a_v[k][c] = ~a_v[k][c];
    end
  endtask

  initial begin
    rstb = 1'b0;
    for (int k = 0; k < NI; k++) a_v[k] = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst");
    for (int k = 0; k < NI; k++) a_v[k] = 8'h00;
    rstb = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      if (!rstb) model_reset();
      else       model_step();
      @(negedge clk);
      check_all("run");
      drive(cyc);
      if (cyc == 600 || cyc == 1100) begin
        rstb = 1'b0;
        model_reset();
        #1;
        check_all("arst");
      end else if (cyc == 603 || cyc == 1102) begin
        rstb = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
